sram_pin_responder: RTL and testbench

SRAM_PIN_RESPONDER -- requirements
Module: sram_pin_responder

---
 rtl/sram_pin_pkg.sv | 13 +
 rtl/sram_pin_mem.sv | 21 ++
 rtl/sram_pin_responder.sv | 139 +++++++++++++
 tb/tb_sram_pin_responder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pin_pkg.sv
// Shared types and constants for the SRAM pin-level responder.
package sram_pin_pkg;

  localparam int CNT_BITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ_WAIT,
    READ_DRIVE
  } state_e;

endpackage

// File: rtl/sram_pin_mem.sv
// Single-port backing store: synchronous write, registered read (EBR-friendly).
module sram_pin_mem #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // NOTE: neither the array nor the read register has a reset; a reset would stop block-RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_pin_responder.sv
// Pin-level asynchronous-SRAM model: decodes CE/WE/OE strobes into writes and latency-delayed reads.
module sram_pin_responder
  import sram_pin_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_BITS-1:0] sram_io_addr_bus,
  inout  wire  [DATA_BITS-1:0] sram_io_data_bus,
  input  logic                 sram_io_ce_n,
  input  logic                 sram_io_we_n,
  input  logic                 sram_io_oe_n,
  output logic [CNT_BITS-1:0]  write_count,
  output logic [CNT_BITS-1:0]  read_count,
  output logic                 bus_conflict
);

  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

  state_e               state, state_nx;
  logic [2:0]           lat_cnt, lat_cnt_nx;
  logic [ADDR_BITS-1:0] rd_addr, rd_addr_nx;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0] wr_data;
  logic [CNT_BITS-1:0]  write_cnt, read_cnt;
  logic                 conflict;
  logic                 we_low, wr_capture, wr_commit, rd_done;
  logic                 bus_oe;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_q;

  assign we_low = !sram_io_ce_n && !sram_io_we_n;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx   = state;
    lat_cnt_nx = lat_cnt;
    rd_addr_nx = rd_addr;
    wr_capture = 1'b0;
    wr_commit  = 1'b0;
    rd_done    = 1'b0;
    if (we_low) begin
      // A write strobe overrides whatever read is in flight.
      state_nx   = WRITE;
      wr_capture = 1'b1;
      rd_done    = (state == READ_DRIVE);
    end else begin
      unique case (state)
        IDLE: begin
          if (!sram_io_ce_n && !sram_io_oe_n) begin
            state_nx   = READ_WAIT;
            rd_addr_nx = sram_io_addr_bus;
            lat_cnt_nx = LAT_LOAD;
          end
        end
        WRITE: begin
          // Reaching here means WE or CE has gone high: the strobe has ended.
          wr_commit = 1'b1;
          state_nx  = IDLE;
        end
        READ_WAIT: begin
          if (sram_io_ce_n || sram_io_oe_n) begin
            state_nx = IDLE;
          end else if (sram_io_addr_bus != rd_addr) begin
            rd_addr_nx = sram_io_addr_bus;
            lat_cnt_nx = LAT_LOAD;
          end else if (lat_cnt == 3'd0) begin
            state_nx = READ_DRIVE;
          end else begin
            lat_cnt_nx = lat_cnt - 3'd1;
          end
        end
        READ_DRIVE: begin
          if (sram_io_ce_n || sram_io_oe_n) begin
            state_nx = IDLE;
            rd_done  = 1'b1;
          end else if (sram_io_addr_bus != rd_addr) begin
            state_nx   = READ_WAIT;
            rd_addr_nx = sram_io_addr_bus;
            lat_cnt_nx = LAT_LOAD;
            rd_done    = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lat_cnt   <= 3'd0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      write_cnt <= '0;
      read_cnt  <= '0;
      conflict  <= 1'b0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_cnt_nx;
      rd_addr <= rd_addr_nx;
      if (wr_capture) begin
        wr_addr <= sram_io_addr_bus;
        wr_data <= sram_io_data_bus;
      end
      if (wr_commit) write_cnt <= write_cnt + CNT_BITS'(1);
      if (rd_done) read_cnt <= read_cnt + CNT_BITS'(1);
      if (we_low && !sram_io_oe_n) conflict <= 1'b1;
    end
  end

  // The read port tracks the latched read address, so a commit always lands before any later read.
  assign mem_addr = wr_commit ? wr_addr : rd_addr;

  sram_pin_mem #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_mem (
    .clk  (clk),
    .we   (wr_commit),
    .addr (mem_addr),
    .wdata(wr_data),
    .rdata(mem_q)
  );

  // Raw pins gate the driver so the bus is released in the same cycle the initiator asks.
  assign bus_oe = (state == READ_DRIVE) && !sram_io_ce_n && !sram_io_oe_n && sram_io_we_n;
  assign sram_io_data_bus = bus_oe ? mem_q : {DATA_BITS{1'bz}};

  assign write_count  = write_cnt;
  assign read_count   = read_cnt;
  assign bus_conflict = conflict;

endmodule

// File: tb/tb_sram_pin_responder.sv
// Directed bench for sram_pin_responder; an undriven bus reads back as all-ones through the pull-up.
module tb_sram_pin_responder;

  localparam logic [15:0] RELEASED = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  addr;
  logic        ce_n, we_n, oe_n;
  logic        drv_en;
  logic [15:0] drv_data;
  tri1  [15:0] data_bus;
  wire  [15:0] write_count, read_count;
  wire         bus_conflict;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign data_bus = drv_en ? drv_data : 16'hzzzz;

  sram_pin_responder #(
    .ADDR_BITS(8),
    .DATA_BITS(16),
    .READ_LATENCY(2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sram_io_addr_bus(addr),
    .sram_io_data_bus(data_bus),
    .sram_io_ce_n    (ce_n),
    .sram_io_we_n    (we_n),
    .sram_io_oe_n    (oe_n),
    .write_count     (write_count),
    .read_count      (read_count),
    .bus_conflict    (bus_conflict)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_pins();
    ce_n   = 1'b1;
    we_n   = 1'b1;
    oe_n   = 1'b1;
    drv_en = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
  endtask

  // One write strobe of `cycles` clocks; ends by raising WE (or CE when end_by_ce) for the commit edge.
  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input int cycles,
                          input bit end_by_ce);
    addr     = a;
    drv_data = d;
    drv_en   = 1'b1;
    ce_n     = 1'b0;
    we_n     = 1'b0;
    oe_n     = 1'b1;
    repeat (cycles) tick();
    we_n   = 1'b1;
    drv_en = 1'b0;
    if (end_by_ce) ce_n = 1'b1;
    tick();
    idle_pins();
  endtask

  task automatic test_reset();
    idle_pins();
    addr     = 8'h00;
    drv_data = 16'h0000;
    reset_n  = 1'b0;
    tick();
    tick();
    checks++;
    if (write_count !== 16'd0) begin errors++; $display("FAIL reset_write_count: got %0d expected 0", write_count); end
    checks++;
    if (read_count !== 16'd0) begin errors++; $display("FAIL reset_read_count: got %0d expected 0", read_count); end
    checks++;
    if (bus_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b expected 0", bus_conflict); end
    checks++;
    if (data_bus !== RELEASED) begin errors++; $display("FAIL reset_bus: got %h expected released", data_bus); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    do_write(8'h13, 16'h0001, 1, 1'b0);
    pulse_reset();
    checks++;
    if (write_count !== 16'd0) begin errors++; $display("FAIL prewrite_cleared: got %0d expected 0", write_count); end
    do_write(8'h12, 16'hA5C3, 2, 1'b0);
    checks++;
    if (write_count !== 16'd1) begin errors++; $display("FAIL wr_count_after_write: got %0d expected 1", write_count); end
    addr = 8'h12;
    ce_n = 1'b0;
    oe_n = 1'b0;
    tick();
    checks++;
    if (data_bus !== RELEASED) begin errors++; $display("FAIL rd_latency_1: got %h expected released", data_bus); end
    tick();
    checks++;
    if (data_bus !== RELEASED) begin errors++; $display("FAIL rd_latency_2: got %h expected released", data_bus); end
    tick();
    checks++;
    if (data_bus !== 16'hA5C3) begin errors++; $display("FAIL rd_data_12: got %h expected a5c3", data_bus); end
    checks++;
    if (read_count !== 16'd0) begin errors++; $display("FAIL rd_count_during_drive: got %0d expected 0", read_count); end
  endtask

  // Continues the READ_DRIVE left by test_write_read.
  task automatic test_addr_change();
    addr = 8'h13;
    tick();
    checks++;
    if (data_bus !== RELEASED) begin errors++; $display("FAIL addr_chg_release: got %h expected released", data_bus); end
    checks++;
    if (read_count !== 16'd1) begin errors++; $display("FAIL addr_chg_read_count: got %0d expected 1", read_count); end
    tick();
    checks++;
    if (data_bus !== RELEASED) begin errors++; $display("FAIL addr_chg_wait: got %h expected released", data_bus); end
    tick();
    checks++;
    if (data_bus !== 16'h0001) begin errors++; $display("FAIL addr_chg_data_13: got %h expected 0001", data_bus); end
    oe_n = 1'b1;
    #1;
    checks++;
    if (data_bus !== RELEASED) begin errors++; $display("FAIL oe_release_zero_cycle: got %h expected released", data_bus); end
    tick();
    checks++;
    if (read_count !== 16'd2) begin errors++; $display("FAIL read_count_after_oe: got %0d expected 2", read_count); end
    idle_pins();
    tick();
  endtask

  task automatic test_conflict();
    addr     = 8'h20;
    drv_data = 16'h00FF;
    drv_en   = 1'b1;
    ce_n     = 1'b0;
    we_n     = 1'b0;
    oe_n     = 1'b0;
    #1;
    checks++;
    if (data_bus !== 16'h00FF) begin errors++; $display("FAIL conflict_no_drive: got %h expected 00ff", data_bus); end
    tick();
    checks++;
    if (bus_conflict !== 1'b1) begin errors++; $display("FAIL conflict_flag: got %b expected 1", bus_conflict); end
    we_n   = 1'b1;
    oe_n   = 1'b1;
    drv_en = 1'b0;
    #1;
    checks++;
    if (data_bus !== RELEASED) begin errors++; $display("FAIL conflict_commit_bus: got %h expected released", data_bus); end
    tick();
    checks++;
    if (write_count !== 16'd2) begin errors++; $display("FAIL conflict_commit_count: got %0d expected 2", write_count); end
    oe_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (data_bus !== 16'h00FF) begin errors++; $display("FAIL conflict_readback_20: got %h expected 00ff", data_bus); end
    checks++;
    if (bus_conflict !== 1'b1) begin errors++; $display("FAIL conflict_sticky: got %b expected 1", bus_conflict); end
  endtask

  // Enters with the responder in READ_DRIVE from test_conflict.
  task automatic test_reset_mid_read();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (data_bus !== RELEASED) begin errors++; $display("FAIL async_reset_release: got %h expected released", data_bus); end
    checks++;
    if ({write_count, read_count} !== 32'd0) begin
      errors++; $display("FAIL async_reset_counters: got wr=%0d rd=%0d expected 0/0", write_count, read_count);
    end
    checks++;
    if (bus_conflict !== 1'b0) begin errors++; $display("FAIL async_reset_conflict: got %b expected 0", bus_conflict); end
    idle_pins();
    tick();
    reset_n = 1'b1;
    tick();
    addr = 8'h12;
    ce_n = 1'b0;
    oe_n = 1'b0;
    tick();
    tick();
    checks++;
    if (data_bus !== RELEASED) begin errors++; $display("FAIL post_reset_latency: got %h expected released", data_bus); end
    tick();
    checks++;
    if (data_bus !== 16'hA5C3) begin errors++; $display("FAIL post_reset_mem_kept: got %h expected a5c3", data_bus); end
    idle_pins();
    tick();
  endtask

  task automatic test_back_to_back();
    logic seen;
    addr     = 8'h00;
    drv_data = 16'h1234;
    drv_en   = 1'b1;
    ce_n     = 1'b0;
    we_n     = 1'b0;
    oe_n     = 1'b1;
    #1;
    checks++;
    if (data_bus !== 16'h1234) begin errors++; $display("FAIL b2b_init_drive: got %h expected 1234", data_bus); end
    tick();
    we_n   = 1'b1;
    oe_n   = 1'b0;
    drv_en = 1'b0;
    #1;
    checks++;
    if (data_bus !== RELEASED) begin errors++; $display("FAIL b2b_turnaround: got %h expected released", data_bus); end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (data_bus !== RELEASED) seen = 1'b1;
    end
    checks++;
    if (data_bus !== 16'h1234) begin errors++; $display("FAIL b2b_read_00: got %h expected 1234", data_bus); end
    idle_pins();
    tick();
  endtask

  task automatic test_counter_wrap();
    pulse_reset();
    tick();
    force dut.write_cnt = 16'hFFF0;
    tick();
    release dut.write_cnt;
    tick();
    checks++;
    if (write_count !== 16'hFFF0) begin errors++; $display("FAIL wrap_preset: got %h expected fff0", write_count); end
    for (int i = 0; i < 16; i++) begin
      do_write(8'(8'h40 + i), 16'(16'h0100 + i), 1, i[0]);
    end
    checks++;
    if (write_count !== 16'd0) begin errors++; $display("FAIL wrap_write_count: got %h expected 0000", write_count); end
    checks++;
    if (bus_conflict !== 1'b0) begin errors++; $display("FAIL wrap_conflict: got %b expected 0", bus_conflict); end
    addr = 8'h47;
    ce_n = 1'b0;
    oe_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (data_bus !== 16'h0107) begin errors++; $display("FAIL wrap_ce_commit_47: got %h expected 0107", data_bus); end
    idle_pins();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_addr_change();
    test_conflict();
    test_reset_mid_read();
    test_back_to_back();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
